// File: rtl/bcd_seg_scanner.sv
// Multiplexed 8-digit 7-segment scanner for the 32-bit BCD time bus, with per-frame snapshot and anode-off blanking.
// Optional leading-zero suppression on digits 7..4 is compiled in with SEG_LZ_BLANK_EN.
module bcd_seg_scanner #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int SCAN_HZ    = 8_000,
  parameter int BLANK_CYC  = 2,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] time_data,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int DIV = CLK_FREQ / SCAN_HZ - 1;
  localparam int CW  = $clog2(DIV + 1);
  localparam int BW  = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   snap;
  logic [BW-1:0] blank_cnt;
  logic          tick;
  logic          lit;
  logic          digit_blank;
  logic [3:0]    digit;
  logic [7:0]    an_raw;
  logic [6:0]    seg_raw;
  logic          dp_raw;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'h3F;
      4'd1:    enc = 7'h06;
      4'd2:    enc = 7'h5B;
      4'd3:    enc = 7'h4F;
      4'd4:    enc = 7'h66;
      4'd5:    enc = 7'h6D;
      4'd6:    enc = 7'h7D;
      4'd7:    enc = 7'h07;
      4'd8:    enc = 7'h7F;
      4'd9:    enc = 7'h6F;
      default: enc = 7'h40;
    endcase
  endfunction

  assign tick  = (cnt == CW'(DIV));
  // The tick cycle is dark too, so each slot change gives BLANK_CYC+1 anode-off cycles.
  assign lit   = (blank_cnt == '0) && !tick;
  assign digit = snap[{idx, 2'b00} +: 4];

`ifdef SEG_LZ_BLANK_EN
  logic [7:0] lz_mask;
  always_comb begin
    logic run;
    run     = 1'b1;
    lz_mask = '0;
    for (int k = 7; k >= 4; k--) begin
      run        = run & (snap[4*k +: 4] == 4'h0);
      lz_mask[k] = run;
    end
  end
  assign digit_blank = lz_mask[idx];
`else
  assign digit_blank = 1'b0;
`endif

  always_comb begin
    an_raw  = lit ? (8'b1 << idx) : 8'h00;
    seg_raw = (lit && !digit_blank) ? enc(digit) : 7'h00;
    dp_raw  = lit && !digit_blank && (idx == 3'd2 || idx == 3'd4 || idx == 3'd6);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      snap       <= '0;
      blank_cnt  <= BW'(BLANK_CYC);
      frame_done <= 1'b0;
      an         <= {8{ACTIVE_LOW}};
      seg        <= {7{ACTIVE_LOW}};
      dp         <= ACTIVE_LOW;
    end else begin
      frame_done <= 1'b0;
      if (tick) begin
        cnt       <= '0;
        idx       <= idx + 3'd1;
        blank_cnt <= BW'(BLANK_CYC);
        if (idx == 3'd7) begin
          snap       <= time_data;
          frame_done <= 1'b1;
        end
      end else begin
        cnt <= cnt + CW'(1);
        if (blank_cnt != '0) blank_cnt <= blank_cnt - BW'(1);
      end
      an  <= an_raw ^ {8{ACTIVE_LOW}};
      seg <= seg_raw ^ {7{ACTIVE_LOW}};
      dp  <= dp_raw ^ ACTIVE_LOW;
    end
  end

endmodule
